spi_host_master: RTL and testbench
==================================

// Module: spi_host_master
// PURPOSE
//   SPI initiator (mode 0, MSB first) that drives the chip's SPI responder pins (sclk/cs/mosi, samples miso).
//   Converts a single-word read/write request into a CMD+ADDR+DATA frame and returns read data.
//   Used as the host-side driver in system benches and as an on-chip bridge to external SPI targets.
// PARAMETERS
//   CLK_DIV        4      i_clk cycles per sclk half-period (>=1)
//   DUMMY_BITS     8      turnaround bits between address and read data (>=0)
//   CS_IDLE_CYCLES 4      min i_clk cycles cs_n stays high between frames (>=0)
//   CMD_WR         8'h02  command byte for write
//   CMD_RD         8'h03  command byte for read
// PORTS
//   i_clk          in   1   system clock
//   i_rst_n        in   1   asynchronous active-low reset
//   i_req_valid    in   1   request present
//   o_req_ready    out  1   high only in IDLE; accept when valid&&ready at rising i_clk
//   i_req_wr       in   1   1=write, 0=read
//   i_req_addr     in   32  target address
//   i_req_wdata    in   32  write data (ignored for read)
//   o_rsp_valid    out  1   1-cycle pulse: frame complete
//   o_rsp_rdata    out  32  read data; 0 after write; held until next response
//   o_busy         out  1   high in any state except IDLE
//   o_sclk         out  1   SPI clock, idle low
//   o_cs_n         out  1   chip select, active low
//   o_mosi         out  1   serial data out
//   i_miso         in   1   serial data in
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, o_sclk=0, o_cs_n=1, o_mosi=0, o_rsp_valid=0, o_rsp_rdata=0,
//     o_busy=0, o_req_ready=1, counters cleared. Reset mid-frame aborts: no o_rsp_valid pulse.
//   Request fields latched on accept; inputs may change afterwards. Requests while busy are not accepted.
//   Frame: write = CMD_WR[7:0], addr[31:0], wdata[31:0] (N=72 bits);
//          read  = CMD_RD[7:0], addr[31:0], DUMMY_BITS zeros, 32 sampled bits (N=72+DUMMY_BITS);
//          o_mosi=0 during dummy and read-data bits.
//   States: IDLE -> SHIFT (on accept) -> HOLD -> GAP -> IDLE (GAP skipped if CS_IDLE_CYCLES=0).
//   SHIFT: cycle after accept o_cs_n=0, o_mosi=frame MSB. Each bit = CLK_DIV cycles sclk low then CLK_DIV high.
//     o_mosi updates only on the cycle sclk falls (i.e. start of each low phase); stable across rising edge.
//     i_miso sampled on the i_clk edge that drives o_sclk 0->1; read data shifted in MSB first from
//     last 32 bits only.
//   HOLD: after last high phase sclk=0, o_cs_n stays 0 for CLK_DIV cycles, then o_cs_n=1.
//   cs_n low duration = 2*N*CLK_DIV + CLK_DIV cycles; exactly N rising sclk edges per frame.
//   o_rsp_valid pulses and o_rsp_rdata updates on the first cycle o_cs_n is high again (entering GAP/IDLE).
//   GAP: CS_IDLE_CYCLES cycles with cs_n=1, ready=0; then IDLE, ready=1 (back-to-back accept allowed
//     on first IDLE cycle).
//   Bit counter width $clog2(72+DUMMY_BITS+1); divider counter $clog2(CLK_DIV+1); no wrap within a frame.
// TESTING
//   Write addr=0x4000_0010 data=0xDEADBEEF, CLK_DIV=2 -> 72 sclk rises, mosi bits = 0x02,addr,data;
//     cs_n low 290 cycles; rsp pulse, rdata=0.
//   Read addr=0x1000_0004, slave model drives 0xCAFEF00D after 8 dummy bits -> 80 sclk rises,
//     rdata=0xCAFEF00D, cs_n low 322 cycles (CLK_DIV=2).
//   Back-to-back: valid held high for 2 reqs -> second accepted exactly CS_IDLE_CYCLES+1 cycles after
//     first cs_n rise; ready=0 throughout frame.
//   Assert i_rst_n low at bit 30 of a write -> cs_n=1, sclk=0 immediately; no rsp pulse; next request
//     runs a full clean frame.
//   CLK_DIV=1, DUMMY_BITS=0, CS_IDLE_CYCLES=0 -> sclk toggles every cycle, read frame 72 bits, correct rdata.
//   Mode-0 check: assertion that o_mosi never changes while o_sclk=1 and o_cs_n never changes while o_sclk=1.

Source files
------------

// File: rtl/spi_host_master.sv
// SPI initiator, mode 0, MSB first. Turns one read/write request into a
// CMD + ADDR + (DATA | DUMMY + read data) frame and returns the read word.
module spi_host_master #(
  parameter int          CLK_DIV        = 4,
  parameter int          DUMMY_BITS     = 8,
  parameter int          CS_IDLE_CYCLES = 4,
  parameter logic [7:0]  CMD_WR         = 8'h02,
  parameter logic [7:0]  CMD_RD         = 8'h03
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_busy,
  output logic        o_sclk,
  output logic        o_cs_n,
  output logic        o_mosi,
  input  logic        i_miso
);

  localparam int N_WR  = 72;
  localparam int N_RD  = 72 + DUMMY_BITS;
  localparam int BIT_W = $clog2(N_RD + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_IDLE_CYCLES > 0) ? CS_IDLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [71:0]       tx_sr;
  logic [31:0]       rx_sr;
  logic              is_wr;
  logic [71:0]       frame_in;
  logic [BIT_W-1:0]  last_bit;

  // Read frames carry zeros where write data would be; the dummy and
  // read-data bits then fall out of the zero-filled shift register.
  assign frame_in = {(i_req_wr ? CMD_WR : CMD_RD), i_req_addr,
                     (i_req_wr ? i_req_wdata : 32'h0)};
  assign last_bit = is_wr ? BIT_W'(N_WR - 1) : BIT_W'(N_RD - 1);

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      is_wr       <= 1'b0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_busy      <= 1'b0;
      o_sclk      <= 1'b0;
      o_cs_n      <= 1'b1;
      o_mosi      <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            state       <= S_SHIFT;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            o_cs_n      <= 1'b0;
            is_wr       <= i_req_wr;
            o_mosi      <= frame_in[71];
            tx_sr       <= {frame_in[70:0], 1'b0};
            div_cnt     <= '0;
            bit_cnt     <= '0;
          end
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!o_sclk) begin
              // Rising sclk edge: the target's bit is sampled here.
              o_sclk <= 1'b1;
              rx_sr  <= {rx_sr[30:0], i_miso};
            end else begin
              o_sclk <= 1'b0;
              if (bit_cnt == last_bit) begin
                state  <= S_HOLD;
                o_mosi <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                o_mosi  <= tx_sr[71];
                tx_sr   <= {tx_sr[70:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            o_cs_n      <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= is_wr ? 32'h0 : rx_sr;
            gap_cnt     <= '0;
            if (CS_IDLE_CYCLES == 0) begin
              state       <= S_IDLE;
              o_req_ready <= 1'b1;
              o_busy      <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Scoreboard bench for spi_host_master: two configurations, a bus-level SPI
// monitor/target model, and expected responses queued at request accept.
module tb_spi_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]  rdata;
    int           nbits;
    int           cs_low;
    logic [127:0] mosi;
  } exp_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [127:0] act, input logic [127:0] exp);
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int CD = (g == 0) ? 2 : 1;
    localparam int DB = (g == 0) ? 8 : 0;
    localparam int CI = (g == 0) ? 4 : 0;

    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        miso = 1'b0;
    logic        ready, rsp_valid, busy, sclk, cs_n, mosi;
    logic [31:0] rdata;
    bit          done_g = 1'b0;

    spi_host_master #(
      .CLK_DIV(CD), .DUMMY_BITS(DB), .CS_IDLE_CYCLES(CI)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(valid), .o_req_ready(ready),
      .i_req_wr(wr), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rdata), .o_busy(busy),
      .o_sclk(sclk), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
    );

    exp_t         exp_q[$];
    logic [31:0]  slave_q[$];
    exp_t         e_cur;
    int           rise_cnt = 0, cs_low = 0, cs_high = 0, last_gap = 0;
    int           rsp_seen = 0, n_exp = 0;
    logic [127:0] mosi_bits = '0;
    logic [31:0]  cur_slave = '0;
    logic         prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_mosi = 1'b0, prev_rst = 1'b0;

    // Bus monitor, target model and response checker, all sampled mid-cycle.
    always @(negedge clk) begin
      if (prev_rst && rst_n) begin
        if (mosi !== prev_mosi && sclk !== 1'b0)
          flag($sformatf("mode0_mosi_cfg%0d", g), {sclk, mosi}, {1'b0, mosi});
        if (cs_n !== prev_cs_n && (sclk !== 1'b0 || prev_sclk !== 1'b0))
          flag($sformatf("mode0_cs_cfg%0d", g), {prev_sclk, sclk}, 2'b00);
        if (cs_n === 1'b0 && (ready !== 1'b0 || busy !== 1'b1))
          flag($sformatf("in_frame_ready_busy_cfg%0d", g), {ready, busy}, 2'b01);
      end
      if (prev_cs_n === 1'b1 && cs_n === 1'b0) begin
        rise_cnt  = 0;
        cs_low    = 0;
        mosi_bits = '0;
        last_gap  = cs_high;
        cur_slave = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0;
      end
      if (cs_n === 1'b0) cs_low++;
      else if (prev_cs_n === 1'b0) cs_high = 1;
      else cs_high++;
      if (cs_n === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
        rise_cnt++;
        mosi_bits = {mosi_bits[126:0], mosi};
      end
      miso = 1'b1;
      if (cs_n === 1'b0 && rise_cnt >= 40 + DB && rise_cnt < 72 + DB)
        miso = cur_slave[31 - (rise_cnt - 40 - DB)];
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          flag($sformatf("unexpected_rsp_cfg%0d", g), 1, 0);
        end else begin
          e_cur = exp_q.pop_front();
          check($sformatf("rdata_cfg%0d", g), rdata, e_cur.rdata);
          check($sformatf("sclk_rises_cfg%0d", g), rise_cnt, e_cur.nbits);
          check($sformatf("cs_low_cycles_cfg%0d", g), cs_low, e_cur.cs_low);
          check($sformatf("mosi_bits_cfg%0d", g), mosi_bits, e_cur.mosi);
        end
      end
      prev_sclk = sclk;
      prev_cs_n = cs_n;
      prev_mosi = mosi;
      prev_rst  = rst_n;
    end

    // Presents a request, waits for accept, queues the expected outcome and
    // then scrambles the request fields to prove they were latched.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] sd, input bit expect_rsp);
      int   t;
      exp_t e;
      @(negedge clk);
      valid = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      t = 0;
      while (ready !== 1'b1 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (ready !== 1'b1) begin
        flag($sformatf("accept_timeout_cfg%0d", g), ready, 1);
        valid = 1'b0;
        return;
      end
      @(posedge clk);
      slave_q.push_back(sd);
      if (expect_rsp) begin
        e.nbits  = w ? 72 : 72 + DB;
        e.cs_low = 2 * e.nbits * CD + CD;
        e.rdata  = w ? 32'h0 : sd;
        if (w) e.mosi = {56'h0, 8'h02, a, d};
        else   e.mosi = {88'h0, 8'h03, a} << (32 + DB);
        exp_q.push_back(e);
        n_exp++;
      end
      #1;
      wr    = ~w;
      addr  = ~a;
      wdata = ~d;
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || ready !== 1'b1) && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (exp_q.size() != 0 || ready !== 1'b1)
        flag($sformatf("idle_timeout_cfg%0d", g), exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, ready, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_cs_n"}, cs_n, 1'b1);
      check({tag, "_sclk"}, sclk, 1'b0);
      check({tag, "_mosi"}, mosi, 1'b0);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rdata"}, rdata, 32'h0);
    endtask

    if (g == 0) begin : g_seq
      initial begin
        int t;
        repeat (3) @(negedge clk);
        check_reset_outputs("cfg0_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 1'b1);
        valid = 1'b0;
        wait_idle();

        send(1'b0, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 1'b1);
        valid = 1'b0;
        wait_idle();

        send(1'b1, 32'h1234_5678, 32'hA5A5_5A5A, 32'h0, 1'b1);
        send(1'b0, 32'h8000_0001, 32'h0, 32'h8765_4321, 1'b1);
        valid = 1'b0;
        wait_idle();
        check("cfg0_b2b_gap", last_gap, CI + 1);

        send(1'b1, 32'h0F0F_0F0F, 32'h1122_3344, 32'h0, 1'b0);
        valid = 1'b0;
        t = 0;
        while (rise_cnt != 30 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        check("cfg0_abort_reached_bit30", rise_cnt, 30);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("cfg0_abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(1'b0, 32'h2000_0008, 32'h0, 32'h0BAD_F00D, 1'b1);
        valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("cfg0_rsp_count", rsp_seen, n_exp);
        done_g = 1'b1;
      end
    end else begin : g_seq
      initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("cfg1_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(1'b0, 32'h0000_00FF, 32'h0, 32'h8BAD_F00D, 1'b1);
        valid = 1'b0;
        wait_idle();

        send(1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0, 1'b1);
        valid = 1'b0;
        wait_idle();

        send(1'b0, 32'h5555_AAAA, 32'h0, 32'hFFFF_0000, 1'b1);
        send(1'b0, 32'hAAAA_5555, 32'h0, 32'h0000_FFFF, 1'b1);
        valid = 1'b0;
        wait_idle();
        check("cfg1_b2b_gap", last_gap, CI + 1);
        repeat (5) @(negedge clk);
        check("cfg1_rsp_count", rsp_seen, n_exp);
        done_g = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (!(g_cfg[0].done_g && g_cfg[1].done_g) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(g_cfg[0].done_g && g_cfg[1].done_g))
      flag("global_timeout", {g_cfg[0].done_g, g_cfg[1].done_g}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
